// File: rtl/sawtooth_freq_meter_if.sv
// Sawtooth frequency meter bus interface.
//   master : drives clear / in_valid / in_value, observes the results
//   slave  : the meter; consumes samples, drives ctrl_est / period / flags
interface sawtooth_freq_meter_if #(
    parameter int N = 32,
    parameter int M = 16,
    parameter int P = 24
);
    logic         clear;
    logic         in_valid;
    logic [M-1:0] in_value;
    logic [N-1:0] ctrl_est;
    logic         est_valid;
    logic [P-1:0] period;
    logic         period_valid;
    logic         locked;

    modport master (
        output clear, in_valid, in_value,
        input  ctrl_est, est_valid, period, period_valid, locked
    );
    modport slave (
        input  clear, in_valid, in_value,
        output ctrl_est, est_valid, period, period_valid, locked
    );
endinterface

// File: rtl/sawtooth_freq_meter.sv
// Sawtooth frequency meter: recovers the generator control word from a stream
// of signed sawtooth samples by averaging sample-to-sample deltas over 2^K
// deltas, and measures the wave period (deltas between positive->negative wraps).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of sawtooth_freq_meter_if
//                (clear, in_valid, in_value -> ctrl_est, est_valid,
//                 period, period_valid, locked)
module sawtooth_freq_meter #(
    parameter int N = 32,
    parameter int M = 16,
    parameter int K = 8,
    parameter int P = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sawtooth_freq_meter_if.slave  bus
);
    localparam int SH = N - M - K;
    localparam logic [K-1:0] CNT_ONE = 1;
    localparam logic [P-1:0] PCNT_ONE = 1;

    typedef enum logic {S_EMPTY, S_RUN}   state_t;
    typedef enum logic {P_SEEK, P_COUNT}  pstate_t;

    state_t         r_state;
    pstate_t        r_pstate;
    logic [M-1:0]   r_prev;
    logic [M+K-1:0] r_sum;
    logic [K-1:0]   r_cnt;
    logic [P-1:0]   r_pcnt;
    logic [N-1:0]   r_ctrl_est;
    logic           r_est_valid;
    logic [P-1:0]   r_period;
    logic           r_period_valid;
    logic           r_seen_est;
    logic           r_seen_per;
    logic           r_locked;

    logic [M-1:0]   w_d;
    logic [M+K-1:0] w_sum_nx;
    logic           w_win_end;
    logic           w_wrap;
    logic [P-1:0]   w_pcnt_inc;

    // Unsigned modular difference: a wrap from max positive to min negative
    // still yields the small positive step.
    assign w_d        = bus.in_value - r_prev;
    assign w_sum_nx   = r_sum + {{K{1'b0}}, w_d};
    assign w_win_end  = (r_cnt == {K{1'b1}});
    assign w_wrap     = ~r_prev[M-1] & bus.in_value[M-1];
    assign w_pcnt_inc = (r_pcnt == {P{1'b1}}) ? r_pcnt : r_pcnt + PCNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_EMPTY;
            r_pstate       <= P_SEEK;
            r_prev         <= '0;
            r_sum          <= '0;
            r_cnt          <= '0;
            r_pcnt         <= '0;
            r_ctrl_est     <= '0;
            r_est_valid    <= 1'b0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_seen_est     <= 1'b0;
            r_seen_per     <= 1'b0;
            r_locked       <= 1'b0;
        end else begin
            r_est_valid    <= 1'b0;
            r_period_valid <= 1'b0;
            // Sticky "has pulsed" flags; locked rises the cycle after the
            // later of the two first pulses.
            r_seen_est     <= r_seen_est | r_est_valid;
            r_seen_per     <= r_seen_per | r_period_valid;
            r_locked       <= r_locked | ((r_seen_est | r_est_valid) &
                                          (r_seen_per | r_period_valid));
            if (bus.clear) begin
                r_state    <= S_EMPTY;
                r_pstate   <= P_SEEK;
                r_prev     <= '0;
                r_sum      <= '0;
                r_cnt      <= '0;
                r_pcnt     <= '0;
                r_ctrl_est <= '0;
                r_period   <= '0;
                r_seen_est <= 1'b0;
                r_seen_per <= 1'b0;
                r_locked   <= 1'b0;
            end else if (bus.in_valid) begin
                r_prev <= bus.in_value;
                case (r_state)
                    S_EMPTY: r_state <= S_RUN;
                    S_RUN: begin
                        if (w_win_end) begin
                            r_ctrl_est  <= N'(w_sum_nx) << SH;
                            r_est_valid <= 1'b1;
                            r_sum       <= '0;
                            r_cnt       <= '0;
                        end else begin
                            r_sum <= w_sum_nx;
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                        case (r_pstate)
                            P_SEEK: begin
                                if (w_wrap) begin
                                    r_pstate <= P_COUNT;
                                    r_pcnt   <= '0;
                                end
                            end
                            P_COUNT: begin
                                if (w_wrap) begin
                                    r_period       <= w_pcnt_inc;
                                    r_period_valid <= 1'b1;
                                    r_pcnt         <= '0;
                                end else begin
                                    r_pcnt <= w_pcnt_inc;
                                end
                            end
                            default: r_pstate <= P_SEEK;
                        endcase
                    end
                    default: r_state <= S_EMPTY;
                endcase
            end
        end
    end

    assign bus.ctrl_est     = r_ctrl_est;
    assign bus.est_valid    = r_est_valid;
    assign bus.period       = r_period;
    assign bus.period_valid = r_period_valid;
    assign bus.locked       = r_locked;
endmodule
